// File: rtl/demux1t8_8_reg.sv
// Registered 1-to-8 demultiplexer with per-lane valid flags, auto-increment
// write pointer and a sticky overwrite error flag.
module demux1t8_8_reg #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       s,
    input  logic             we,
    input  logic             auto,
    input  logic             clr,
    input  logic [7:0]       ack,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7,
    output logic [7:0]       vld,
    output logic [2:0]       ptr,
    output logic             ovf
);

    logic [WIDTH-1:0] lane_q [8];
    logic [WIDTH-1:0] lane_d [8];
    logic [7:0]       vld_q, vld_d;
    logic [2:0]       ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       tgt;

    always_comb begin
        lane_d = lane_q;
        vld_d  = vld_q;
        ptr_d  = ptr_q;
        ovf_d  = ovf_q;
        tgt    = auto ? ptr_q : s;
        if (clr) begin
            // Clear wins over write and ack; lane data is deliberately kept.
            vld_d = '0;
            ptr_d = '0;
            ovf_d = 1'b0;
        end else begin
            vld_d = vld_q & ~ack;
            if (we) begin
                lane_d[tgt] = I;
                vld_d[tgt]  = 1'b1;
                if (vld_q[tgt] && !ack[tgt]) begin
                    ovf_d = 1'b1;
                end
                if (auto) begin
                    ptr_d = ptr_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '{default: RST_VAL};
            vld_q  <= '0;
            ptr_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            lane_q <= lane_d;
            vld_q  <= vld_d;
            ptr_q  <= ptr_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o0  = lane_q[0];
    assign o1  = lane_q[1];
    assign o2  = lane_q[2];
    assign o3  = lane_q[3];
    assign o4  = lane_q[4];
    assign o5  = lane_q[5];
    assign o6  = lane_q[6];
    assign o7  = lane_q[7];
    assign vld = vld_q;
    assign ptr = ptr_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_demux1t8_8_reg.sv
// Bench for demux1t8_8_reg: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural lane model.
module tb_demux1t8_8_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] I;
  logic [2:0]   s;
  logic         we, auto, clr;
  logic [7:0]   ack;
  logic [W-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0]   vld;
  logic [2:0]   ptr;
  logic         ovf;

  // Handshake: we/ack are single-cycle strobes sampled on the rising edge;
  // there is no back-pressure, every strobe present at an edge takes effect.

  demux1t8_8_reg dut (
    .clk(clk), .rst_n(rst_n), .I(I), .s(s), .we(we), .auto(auto),
    .clr(clr), .ack(ack),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .vld(vld), .ptr(ptr), .ovf(ovf)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // behavioural model: lanes as a plain array, pointer as an integer count
  logic [W-1:0] m_lane [8];
  bit           m_vld  [8];
  int           m_ptr;
  bit           m_ovf;

  function automatic logic [W-1:0] dut_o(input int k);
    case (k)
      0: return o0;
      1: return o1;
      2: return o2;
      3: return o3;
      4: return o4;
      5: return o5;
      6: return o6;
      default: return o7;
    endcase
  endfunction

  function automatic logic [7:0] m_vld_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_vld[k];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_lane[k] = '0;
      m_vld[k]  = 1'b0;
    end
    m_ptr = 0;
    m_ovf = 1'b0;
  endtask

  // one clock edge worth of behaviour, read from the inputs being applied
  task automatic model_step();
    int t;
    bit old_vld [8];
    if (!rst_n) begin
      model_reset();
    end else if (clr) begin
      for (int k = 0; k < 8; k++) m_vld[k] = 1'b0;
      m_ptr = 0;
      m_ovf = 1'b0;
    end else begin
      old_vld = m_vld;
      t = auto ? m_ptr : int'(s);
      for (int k = 0; k < 8; k++) if (ack[k]) m_vld[k] = 1'b0;
      if (we) begin
        if (old_vld[t] && !ack[t]) m_ovf = 1'b1;
        m_lane[t] = I;
        m_vld[t]  = 1'b1;
        if (auto) m_ptr = (m_ptr + 1) % 8;
      end
    end
  endtask

  // compare process: outputs against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 8; k++) chk($sformatf("model_o%0d", k), 32'(dut_o(k)), 32'(m_lane[k]));
      chk("model_vld", 32'(vld), 32'(m_vld_vec()));
      chk("model_ptr", 32'(ptr), 32'(m_ptr));
      chk("model_ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  // driver task: apply one cycle of inputs, advance model on the edge
  task automatic drive(input bit we_v, input bit auto_v, input logic [2:0] s_v,
                       input logic [W-1:0] i_v, input logic [7:0] ack_v, input bit clr_v);
    we = we_v; auto = auto_v; s = s_v; I = i_v; ack = ack_v; clr = clr_v;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, '0, 8'h00, 1'b0);
  endtask

  logic [W-1:0] fill_v [8];

  initial begin
    fill_v = '{8'hA0, 8'h51, 8'hA2, 8'h53, 8'hA4, 8'h55, 8'hA6, 8'h57};
    rst_n = 1'b0; we = 1'b0; auto = 1'b0; s = '0; I = '0; ack = '0; clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_o0", 32'(o0), 32'h0);
    chk("rst_o7", 32'(o7), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_ptr", 32'(ptr), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // manual fill
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 3'(k), fill_v[k], 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) chk($sformatf("fill_o%0d", k), 32'(dut_o(k)), 32'(fill_v[k]));
    chk("fill_vld", 32'(vld), 32'hFF);
    chk("fill_ovf", 32'(ovf), 32'h0);

    // clear beats a coincident write
    drive(1'b1, 1'b0, 3'd3, 8'hEE, 8'h00, 1'b1);
    chk("clr_vld", 32'(vld), 32'h0);
    chk("clr_ptr", 32'(ptr), 32'h0);
    chk("clr_ovf", 32'(ovf), 32'h0);
    chk("clr_o3", 32'(o3), 32'h53);

    // auto pointer wrap, each write acked on the following cycle
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b1, 3'd6, 8'(8'h10 + k), 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'd0, '0, 8'hFF, 1'b0);
    end
    chk("wrap_o0", 32'(o0), 32'h18);
    chk("wrap_o1", 32'(o1), 32'h11);
    chk("wrap_ptr", 32'(ptr), 32'h1);
    chk("wrap_ovf", 32'(ovf), 32'h0);

    // overwrite without ack sets the sticky flag
    drive(1'b1, 1'b0, 3'd2, 8'h3C, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 3'd2, 8'hC3, 8'h00, 1'b0);
    chk("ovw_o2", 32'(o2), 32'hC3);
    chk("ovw_vld2", 32'(vld[2]), 32'h1);
    chk("ovw_ovf", 32'(ovf), 32'h1);
    repeat (3) idle();
    drive(1'b0, 1'b0, 3'd0, '0, 8'hFF, 1'b0);
    chk("ovf_sticky", 32'(ovf), 32'h1);
    drive(1'b0, 1'b0, 3'd0, '0, 8'h00, 1'b1);
    chk("ovf_cleared", 32'(ovf), 32'h0);

    // write and ack on the same lane in the same cycle
    drive(1'b1, 1'b0, 3'd5, 8'h77, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 3'd5, 8'h99, 8'h20, 1'b0);
    chk("ackw_o5", 32'(o5), 32'h99);
    chk("ackw_vld5", 32'(vld[5]), 32'h1);
    chk("ackw_ovf", 32'(ovf), 32'h0);

    // randomized traffic
    repeat (400) begin
      drive($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            W'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
            $urandom_range(0, 49) == 0);
    end

    // asynchronous reset between edges after a fill
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 3'(k), fill_v[k], 8'h00, 1'b0);
    we = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("arst_o%0d", k), 32'(dut_o(k)), 32'h0);
    chk("arst_vld", 32'(vld), 32'h0);
    chk("arst_ptr", 32'(ptr), 32'h0);
    @(negedge clk);

    // write coincident with reset is dropped, first write after release lands
    drive(1'b1, 1'b0, 3'd1, 8'hAB, 8'h00, 1'b0);
    rst_n = 1'b1;
    chk("rstw_vld", 32'(vld), 32'h0);
    chk("rstw_o1", 32'(o1), 32'h0);
    drive(1'b1, 1'b0, 3'd1, 8'hCD, 8'h00, 1'b0);
    chk("post_rst_o1", 32'(o1), 32'hCD);
    chk("post_rst_vld", 32'(vld), 32'h02);

    repeat (60) begin
      drive($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            W'($urandom), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00, 1'b0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux1t8_8_reg.md
DEMUX1T8_8_REG -- requirements
Module: demux1t8_8_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, lane data width in bits.
REQ-002 SHALL provide parameter RST_VAL, default 0, reset value of every data lane.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port I  input  WIDTH  write data.
REQ-006 SHALL have port s  input  3  lane select, used when auto=0.
REQ-007 SHALL have port we  input  1  write strobe, one write per cycle when high.
REQ-008 SHALL have port auto  input  1  1 = target lane from internal pointer, s ignored.
REQ-009 SHALL have port clr  input  1  synchronous clear of vld, ptr and ovf.
REQ-010 SHALL have port ack  input  8  per-lane consume strobe, bit k clears vld[k].
REQ-011 SHALL have ports o0..o7  output  WIDTH each  registered lane data.
REQ-012 SHALL have port vld  output  8  per-lane data-valid flags.
REQ-013 SHALL have port ptr  output  3  auto-mode write pointer.
REQ-014 SHALL have port ovf  output  1  sticky overwrite error flag.

Function
REQ-015 SHALL compute target lane t = auto ? ptr : s, combinationally, in the cycle of the write.
REQ-016 SHALL, on a clock edge with we=1 and clr=0, load I into lane ot and set vld[t]; o_t and vld[t] are visible one cycle after the strobe (latency 1).
REQ-017 SHALL leave all non-target lanes' data unchanged on a write.
REQ-018 SHALL, on ack[k]=1, clear vld[k] at the next edge; multiple ack bits may be asserted together.
REQ-019 SHALL give a write priority over ack on the same lane in the same cycle: vld[t] stays 1, ovf not set.
REQ-020 SHALL set ovf when we=1 targets a lane with vld[t]=1 and ack[t]=0; the new data still overwrites the lane.
REQ-021 SHALL hold ovf at 1 until clr or reset.
REQ-022 SHALL increment ptr by 1 after each write made with auto=1, wrapping 7 -> 0; ptr unchanged for writes with auto=0 or cycles with we=0.
REQ-023 SHALL, on clr=1, clear vld to 0, ptr to 0 and ovf to 0 at the next edge, ignoring we and ack that cycle; lane data retained.
REQ-024 SHALL treat auto as sampled per cycle; switching mode mid-stream leaves ptr at its current value.
REQ-025 SHALL never drive any output combinationally from inputs; all outputs come from registers.

Reset
REQ-026 SHALL, while rst_n=0, immediately force o0..o7=RST_VAL, vld=8'h00, ptr=0, ovf=0, independent of clk.
REQ-027 SHALL discard a write coincident with reset assertion; the first write is accepted on the first rising edge with rst_n=1.
REQ-028 SHALL resume from the reset state after reset is asserted mid-sequence; no partial state survives.

Verification
REQ-029 SHALL cover manual fill: auto=0, write I=8'hA0,8'h51,8'hA2,8'h53,8'hA4,8'h55,8'hA6,8'h57 with s=0..7 -> o0..o7 equal those values, vld=8'hFF, ovf=0.
REQ-030 SHALL cover auto wrap: auto=1, nine writes 8'h10..8'h18 with all lanes acked after each -> o0=8'h18, o1=8'h11, ptr=1, ovf=0.
REQ-031 SHALL cover overwrite: write 8'h3C to s=2, then 8'hC3 to s=2 without ack -> o2=8'hC3, vld[2]=1, ovf=1 persisting until clr.
REQ-032 SHALL cover same-cycle ack+write: vld[5]=1, ack=8'h20 with we=1,s=5,I=8'h99 -> o5=8'h99, vld[5]=1, ovf=0.
REQ-033 SHALL cover clr priority: clr=1 with we=1,s=3,I=8'hEE -> vld=8'h00, ptr=0, ovf=0, o3 unchanged.
REQ-034 SHALL cover async reset: drop rst_n between clock edges after a fill -> outputs reach RST_VAL, vld=0 before the next edge.
